// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with valid/ready handshakes on both sides.
//               Logic and compare ops finish in one cycle. Shifts move one
//               bit per cycle. The optional MUL is a shift-add multiplier
//               that takes WIDTH cycles.
// Config      : ALU_MC_MUL_EN - when defined, op 10 is MUL; otherwise op 10
//               is an undefined code (returns inp1, single-cycle).
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready, alu_control[3:0], inp1, inp2  - request
//               out_valid/out_ready, alu_result, zero_flag       - response
//               busy - high while an iterative op is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Counter must hold WIDTH for the multiplier, hence one extra bit.
    localparam int c_CW = SHW + 1;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;
`ifdef ALU_MC_MUL_EN
    localparam logic [3:0]      c_OP_MUL     = 4'd10;
    localparam logic [c_CW-1:0] c_MUL_CYCLES = c_CW'(WIDTH);
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic [SHW-1:0]   w_shamt;
    logic             w_is_shift;
    logic             w_is_mul;
    logic             w_multi;
    logic             w_last;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_busy_result;

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    assign w_is_mul   = (alu_control == c_OP_MUL);
    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
    assign w_busy_result = (r_op == c_OP_MUL) ? w_acc_next : w_a_next;
`else
    assign w_is_mul      = 1'b0;
    assign w_busy_result = w_a_next;
`endif

    assign in_ready   = (r_state == c_IDLE);
    assign out_valid  = (r_state == c_DONE);
    assign busy       = (r_state == c_BUSY);
    assign alu_result = r_result;
    assign zero_flag  = r_zero;

    assign w_shamt    = inp2[SHW-1:0];
    assign w_is_shift = (alu_control == c_OP_SLL) || (alu_control == c_OP_SRL) ||
                        (alu_control == c_OP_SRA);
    assign w_multi    = (w_is_shift && (w_shamt != '0)) || w_is_mul;
    assign w_last     = (r_cnt == c_CW'(1));

    // Single-cycle result. Shifts only take this path with amount 0, so
    // they fall into the default (inp1) and no barrel shifter is built.
    always_comb begin
        w_alu = inp1;
        case (alu_control)
            c_OP_ADD:  w_alu = inp1 + inp2;
            c_OP_SUB:  w_alu = inp1 - inp2;
            c_OP_AND:  w_alu = inp1 & inp2;
            c_OP_OR:   w_alu = inp1 | inp2;
            c_OP_XOR:  w_alu = inp1 ^ inp2;
            c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
            c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (inp1 < inp2)};
            default:   w_alu = inp1;
        endcase
    end

    // One-bit step of the iterative datapath. The left shift also serves
    // as the multiplicand shift for MUL.
    always_comb begin
        w_a_next = r_a << 1;
        case (r_op)
            c_OP_SRL: w_a_next = r_a >> 1;
            c_OP_SRA: w_a_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            default:  w_a_next = r_a << 1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid) w_state_next = w_multi ? c_BUSY : c_DONE;
            c_BUSY:  if (w_last) w_state_next = c_DONE;
            c_DONE:  if (out_ready) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
`ifdef ALU_MC_MUL_EN
            r_b      <= '0;
            r_acc    <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op <= alu_control;
                        r_a  <= inp1;
`ifdef ALU_MC_MUL_EN
                        r_b   <= inp2;
                        r_acc <= '0;
                        if (w_is_mul) begin
                            r_cnt <= c_MUL_CYCLES;
                        end else
`endif
                        if (w_is_shift) begin
                            r_cnt <= {1'b0, w_shamt};
                        end
                        if (!w_multi) begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                        end
                    end
                end
                c_BUSY: begin
                    r_cnt <= r_cnt - c_CW'(1);
                    r_a   <= w_a_next;
`ifdef ALU_MC_MUL_EN
                    r_b   <= r_b >> 1;
                    r_acc <= w_acc_next;
`endif
                    if (w_last) begin
                        r_result <= w_busy_result;
                        r_zero   <= (w_busy_result == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_mc
// Description : Self-checking bench for alu_mc (WIDTH=32). Directed vector
//               table, hand-written reset/abort sequences, and random ops
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_control = 4'd0;
    logic [W-1:0] inp1 = '0;
    logic [W-1:0] inp2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] alu_result;
    logic         zero_flag;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .inp1       (inp1),
        .inp2       (inp2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero_flag  (zero_flag),
        .busy       (busy)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
        int           hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: results straight from the op-code definitions.
    function automatic logic [W-1:0] model_result(input logic [3:0] op,
                                                  input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        int unsigned sh;
        longint unsigned prod;
        sh   = b % W;
        prod = longint'(a) * longint'(b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return W'($signed(a) >>> sh);
            4'd8: return W'(($signed(a) < $signed(b)) ? 1 : 0);
            4'd9: return W'((a < b) ? 1 : 0);
`ifdef ALU_MC_MUL_EN
            4'd10: return prod[W-1:0];
`endif
            default: return a;
        endcase
    endfunction

    // Cycles from the accept edge until out_valid is seen.
    function automatic int model_latency(input logic [3:0] op, input logic [W-1:0] b);
        int sh;
        sh = int'(b % W);
        if ((op == 4'd5 || op == 4'd6 || op == 4'd7) && sh != 0) return sh + 1;
`ifdef ALU_MC_MUL_EN
        if (op == 4'd10) return W + 1;
`endif
        return 1;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input int exp_lat, input int hold);
        int wait_cnt;
        int lat;
        int busy_cycles;
        int unstable;
        logic [W-1:0] held;
        wait_cnt = 0;
        lat = 0;
        busy_cycles = 0;
        unstable = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        alu_control = op;
        inp1        = a;
        inp2        = b;
        @(posedge clk);
        #1;
        // Scramble inputs after the accept; the result must not notice.
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        inp1        = $urandom;
        inp2        = $urandom;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
        end while (!out_valid && lat < 200);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(alu_result), 64'(exp_res));
        check({tag, " zero"}, 64'(zero_flag), 64'(exp_res == '0));
        check({tag, " busy cycles"}, 64'(busy_cycles), 64'(exp_lat - 1));
        check({tag, " in_ready in done"}, 64'(in_ready), 64'd0);
        held = alu_result;
        repeat (hold) begin
            @(negedge clk);
            if (!out_valid || alu_result !== held || in_ready || zero_flag !== (held == '0))
                unstable++;
            inp1 = $urandom;
        end
        check({tag, " hold stable"}, 64'(unstable), 64'd0);
        // Offer a new request in the leaving cycle; it must not be taken.
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        alu_control = 4'd0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready after"}, 64'(in_ready), 64'd1);
    endtask

    vec_t vecs[$];

    initial begin
        int seen;
        vec_t v;
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // ---------------- reset, with in_valid high (must be ignored)
        rst_n = 1'b0;
        in_valid = 1'b1;
        alu_control = 4'd0;
        inp1 = 32'd5;
        inp2 = 32'd7;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset alu_result", 64'(alu_result), 64'd0);
        check("reset zero_flag", 64'(zero_flag), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post reset out_valid", 64'(out_valid), 64'd0);

        // ---------------- directed vector table
        vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'h1,        32'h0,         1,  10});
        vecs.push_back('{4'd7,  32'h8000_0000, 32'h24,       32'hF800_0000, 5,  2});
        vecs.push_back('{4'd8,  32'hFFFF_FFFF, 32'h1,        32'h1,         1,  1});
        vecs.push_back('{4'd9,  32'hFFFF_FFFF, 32'h1,        32'h0,         1,  1});
`ifdef ALU_MC_MUL_EN
        vecs.push_back('{4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 33, 1});
        vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0});
`else
        vecs.push_back('{4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0001_0001, 1, 1});
`endif
        vecs.push_back('{4'd1,  32'h0,         32'h1,        32'hFFFF_FFFF, 1,  0});
        vecs.push_back('{4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 0});
        vecs.push_back('{4'd3,  32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1, 0});
        vecs.push_back('{4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, 0});
        vecs.push_back('{4'd5,  32'h1234_5678, 32'h20,       32'h1234_5678, 1,  0});
        vecs.push_back('{4'd5,  32'h8000_0001, 32'h1,        32'h0000_0002, 2,  0});
        vecs.push_back('{4'd6,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32, 0});
        vecs.push_back('{4'd7,  32'h7000_0000, 32'h3,        32'h0E00_0000, 4,  0});
        vecs.push_back('{4'd15, 32'hDEAD_BEEF, 32'h1,        32'hDEAD_BEEF, 1,  0});
        foreach (vecs[i]) begin
            v = vecs[i];
            run_op($sformatf("vec%0d op%0d", i, v.op), v.op, v.a, v.b, v.res, v.lat, v.hold);
        end

        // ---------------- reset mid-SLL amount 31 aborts the op
        @(negedge clk);
        in_valid = 1'b1;
        alu_control = 4'd5;
        inp1 = 32'h1;
        inp2 = 32'd31;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        in_valid = 1'b1;
        alu_control = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort no result", 64'(seen), 64'd0);

        // ---------------- reset while DONE drops the pending result
        in_valid = 1'b1;
        alu_control = 4'd3;
        inp1 = 32'h5;
        inp2 = 32'hA;
        @(negedge clk);
        in_valid = 1'b0;
        check("done before reset", 64'(out_valid), 64'd1);
        check("done result", 64'(alu_result), 64'hF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("done reset out_valid", 64'(out_valid), 64'd0);
        check("done reset alu_result", 64'(alu_result), 64'd0);

        // ---------------- random ops against the reference model
        for (int n = 0; n < 150; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 | $urandom_range(0, 3) : $urandom;
            rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, model_result(rop, ra, rb),
                   model_latency(rop, rb), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
